// File: rtl/hex_counter_display.sv
// Hex up/down counter driven by a clock-enable divider, with a registered
// active-low seven-segment display and optional leading-zero blanking.
module hex_counter_display #(
    parameter int NDIGITS = 4,
    parameter int DIV     = 50000000,
    parameter int LZB     = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   up,
    input  logic                   load,
    input  logic [4*NDIGITS-1:0]   load_val,
    output logic [4*NDIGITS-1:0]   value,
    output logic                   tick,
    output logic                   wrap,
    output logic [7*NDIGITS-1:0]   HEX
);

    localparam int W  = 4 * NDIGITS;
    localparam int HW = 7 * NDIGITS;
    localparam int DW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Display image of a zero count: digit 0 shows "0", upper digits follow LZB.
    function automatic logic [HW-1:0] zero_pattern();
        logic [HW-1:0] p;
        for (int i = 0; i < NDIGITS; i++) begin
            p[7*i +: 7] = (i == 0 || LZB == 0) ? 7'h40 : 7'h7F;
        end
        return p;
    endfunction

    localparam logic [HW-1:0] HEX_RST = zero_pattern();

    logic [DW-1:0] div_cnt_reg, div_cnt_next;
    logic [W-1:0]  value_reg, value_next;
    logic          tick_reg, tick_next;
    logic          wrap_reg, wrap_next;
    logic [HW-1:0] hex_reg, hex_next;

    always_comb begin
        div_cnt_next = div_cnt_reg;
        value_next   = value_reg;
        tick_next    = 1'b0;
        wrap_next    = 1'b0;
        if (load) begin
            value_next   = load_val;
            div_cnt_next = '0;
        end else if (en) begin
            if (div_cnt_reg == DIV_LAST) begin
                div_cnt_next = '0;
                tick_next    = 1'b1;
                if (up) begin
                    value_next = value_reg + W'(1);
                    wrap_next  = (value_reg == {W{1'b1}});
                end else begin
                    value_next = value_reg - W'(1);
                    wrap_next  = (value_reg == '0);
                end
            end else begin
                div_cnt_next = div_cnt_reg + DW'(1);
            end
        end
    end

    // A digit above 0 blanks when it and every more significant nibble is zero.
    generate
        for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_digit
            if (gi == 0) begin : g_lsd
                assign hex_next[6:0] = seg7(value_reg[3:0]);
            end else begin : g_upper
                logic blank;
                assign blank = (LZB != 0) && (value_reg[W-1:4*gi] == '0);
                assign hex_next[7*gi +: 7] = blank ? 7'h7F : seg7(value_reg[4*gi +: 4]);
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_reg <= '0;
            value_reg   <= '0;
            tick_reg    <= 1'b0;
            wrap_reg    <= 1'b0;
            hex_reg     <= HEX_RST;
        end else begin
            div_cnt_reg <= div_cnt_next;
            value_reg   <= value_next;
            tick_reg    <= tick_next;
            wrap_reg    <= wrap_next;
            hex_reg     <= hex_next;
        end
    end

    assign value = value_reg;
    assign tick  = tick_reg;
    assign wrap  = wrap_reg;
    assign HEX   = hex_reg;

endmodule

// File: tb/tb_hex_counter_display.sv
// Self-checking bench: two 2-digit counters (blanking on / off) share stimulus and
// are compared every cycle against an arithmetic model of the counter and display.
module tb_hex_counter_display;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0, up = 1'b1, load = 1'b0;
    logic [7:0]  load_val = 8'h00;
    logic [7:0]  value, value0;
    logic        tick, wrap, tick0, wrap0;
    logic [13:0] HEX, HEX0;

    int checks = 0;
    int errors = 0;

    // model state
    int          m_value, m_phase;
    logic        m_tick, m_wrap;
    logic [13:0] m_hex, m_hex0;

    logic [6:0] segtab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    hex_counter_display #(.NDIGITS(2), .DIV(DIV), .LZB(1)) dut (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
        .value(value), .tick(tick), .wrap(wrap), .HEX(HEX));

    hex_counter_display #(.NDIGITS(2), .DIV(DIV), .LZB(0)) dut0 (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
        .value(value0), .tick(tick0), .wrap(wrap0), .HEX(HEX0));

    always #5 clk = ~clk;

    function automatic logic [13:0] exp_hex(input int v, input bit lzb);
        logic [13:0] h;
        for (int i = 0; i < 2; i++) begin
            if (lzb && i >= 1 && (v >> (4 * i)) == 0) h[7*i +: 7] = 7'h7F;
            else h[7*i +: 7] = segtab[(v >> (4 * i)) % 16];
        end
        return h;
    endfunction

    task automatic model_reset();
        m_value = 0; m_phase = 0; m_tick = 1'b0; m_wrap = 1'b0;
        m_hex = exp_hex(0, 1'b1); m_hex0 = exp_hex(0, 1'b0);
    endtask

    // Advance one clock edge, updating the model from the inputs the DUT just sampled.
    task automatic step_cycle();
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            m_hex  = exp_hex(m_value, 1'b1);
            m_hex0 = exp_hex(m_value, 1'b0);
            m_tick = 1'b0;
            m_wrap = 1'b0;
            if (load) begin
                m_value = int'(load_val);
                m_phase = 0;
            end else if (en) begin
                m_phase++;
                if (m_phase == DIV) begin
                    m_phase = 0;
                    m_tick  = 1'b1;
                    m_wrap  = up ? (m_value == 255) : (m_value == 0);
                    m_value = up ? (m_value + 1) % 256 : (m_value + 255) % 256;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        load = 1'b1; load_val = 8'hAB; en = 1'b1; up = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step_cycle();
            checks++;
            if ({value, tick, wrap, HEX, HEX0} !== {8'(m_value), m_tick, m_wrap, m_hex, m_hex0}) begin
                errors++;
                $display("FAIL reset c%0d: got v=%h t=%b w=%b hex=%h/%h need v=%h t=%b w=%b hex=%h/%h",
                         c, value, tick, wrap, HEX, HEX0, 8'(m_value), m_tick, m_wrap, m_hex, m_hex0);
            end
        end
        checks++;
        if (HEX !== {7'h7F, 7'h40} || HEX0 !== {7'h40, 7'h40}) begin
            errors++;
            $display("FAIL reset_hex: got %h/%h need %h/%h", HEX, HEX0, {7'h7F, 7'h40}, {7'h40, 7'h40});
        end
        load = 1'b0; en = 1'b0; up = 1'b1;
        reset = 1'b0;
    endtask

    task automatic test_count_up();
        en = 1'b1; up = 1'b1;
        for (int c = 0; c < 12; c++) begin
            step_cycle();
            checks++;
            if ({value, tick, wrap, HEX, HEX0} !== {8'(m_value), m_tick, m_wrap, m_hex, m_hex0}) begin
                errors++;
                $display("FAIL count_up c%0d: got v=%h t=%b w=%b hex=%h/%h need v=%h t=%b w=%b hex=%h/%h",
                         c, value, tick, wrap, HEX, HEX0, 8'(m_value), m_tick, m_wrap, m_hex, m_hex0);
            end
        end
        checks++;
        if (value !== 8'h03) begin
            errors++;
            $display("FAIL count_up_final: got %h need 03", value);
        end
    endtask

    task automatic test_wrap_up();
        load = 1'b1; load_val = 8'hFF; en = 1'b0;
        step_cycle();
        load = 1'b0; en = 1'b1; up = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step_cycle();
            checks++;
            if ({value, tick, wrap, HEX, HEX0} !== {8'(m_value), m_tick, m_wrap, m_hex, m_hex0}) begin
                errors++;
                $display("FAIL wrap_up c%0d: got v=%h t=%b w=%b hex=%h/%h need v=%h t=%b w=%b hex=%h/%h",
                         c, value, tick, wrap, HEX, HEX0, 8'(m_value), m_tick, m_wrap, m_hex, m_hex0);
            end
            if (c == 3) begin
                checks++;
                if ({value, tick, wrap} !== {8'h00, 1'b1, 1'b1}) begin
                    errors++;
                    $display("FAIL wrap_up_step: got v=%h t=%b w=%b need v=00 t=1 w=1", value, tick, wrap);
                end
            end
        end
        checks++;
        if (HEX !== {7'h7F, 7'h40}) begin
            errors++;
            $display("FAIL wrap_up_hex: got %h need %h", HEX, {7'h7F, 7'h40});
        end
    endtask

    task automatic test_wrap_down();
        load = 1'b1; load_val = 8'h00; en = 1'b0;
        step_cycle();
        load = 1'b0; en = 1'b1; up = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step_cycle();
            checks++;
            if ({value, tick, wrap, HEX, HEX0} !== {8'(m_value), m_tick, m_wrap, m_hex, m_hex0}) begin
                errors++;
                $display("FAIL wrap_down c%0d: got v=%h t=%b w=%b hex=%h/%h need v=%h t=%b w=%b hex=%h/%h",
                         c, value, tick, wrap, HEX, HEX0, 8'(m_value), m_tick, m_wrap, m_hex, m_hex0);
            end
        end
        checks++;
        if (value !== 8'hFF || HEX !== {7'h0E, 7'h0E}) begin
            errors++;
            $display("FAIL wrap_down_final: got v=%h hex=%h need v=ff hex=%h", value, HEX, {7'h0E, 7'h0E});
        end
    endtask

    task automatic test_load_mid();
        load = 1'b1; load_val = 8'h00; en = 1'b0; up = 1'b1;
        step_cycle();
        load = 1'b0; en = 1'b1;
        step_cycle();
        step_cycle();
        load = 1'b1; load_val = 8'h3A;
        for (int c = 0; c < 6; c++) begin
            step_cycle();
            load = 1'b0;
            checks++;
            if ({value, tick, wrap, HEX, HEX0} !== {8'(m_value), m_tick, m_wrap, m_hex, m_hex0}) begin
                errors++;
                $display("FAIL load_mid c%0d: got v=%h t=%b w=%b hex=%h/%h need v=%h t=%b w=%b hex=%h/%h",
                         c, value, tick, wrap, HEX, HEX0, 8'(m_value), m_tick, m_wrap, m_hex, m_hex0);
            end
            if (c == 4) begin
                checks++;
                if ({value, tick} !== {8'h3B, 1'b1}) begin
                    errors++;
                    $display("FAIL load_mid_step: got v=%h t=%b need v=3b t=1", value, tick);
                end
            end
        end
    endtask

    task automatic test_en_pause();
        load = 1'b1; load_val = 8'h10; en = 1'b0; up = 1'b1;
        step_cycle();
        load = 1'b0;
        for (int c = 0; c < 9; c++) begin
            en = (c < 2 || c >= 7);
            step_cycle();
            checks++;
            if ({value, tick, wrap, HEX, HEX0} !== {8'(m_value), m_tick, m_wrap, m_hex, m_hex0}) begin
                errors++;
                $display("FAIL en_pause c%0d: got v=%h t=%b w=%b hex=%h/%h need v=%h t=%b w=%b hex=%h/%h",
                         c, value, tick, wrap, HEX, HEX0, 8'(m_value), m_tick, m_wrap, m_hex, m_hex0);
            end
        end
        checks++;
        if ({value, tick} !== {8'h11, 1'b1}) begin
            errors++;
            $display("FAIL en_pause_step: got v=%h t=%b need v=11 t=1", value, tick);
        end
    endtask

    task automatic test_lzb0();
        load = 1'b1; load_val = 8'h05; en = 1'b0;
        step_cycle();
        load = 1'b0;
        step_cycle();
        checks++;
        if (HEX0 !== {7'h40, 7'h12} || HEX !== {7'h7F, 7'h12}) begin
            errors++;
            $display("FAIL lzb0_hex: got %h/%h need %h/%h", HEX0, HEX, {7'h40, 7'h12}, {7'h7F, 7'h12});
        end
        en = 1'b1;
        step_cycle();
        step_cycle();
        reset = 1'b1;
        #1;
        model_reset();
        checks++;
        if ({value, value0, tick, wrap, HEX, HEX0} !==
            {8'h00, 8'h00, 1'b0, 1'b0, {7'h7F, 7'h40}, {7'h40, 7'h40}}) begin
            errors++;
            $display("FAIL async_reset: got v=%h/%h t=%b w=%b hex=%h/%h need v=00 hex=%h/%h",
                     value, value0, tick, wrap, HEX, HEX0, {7'h7F, 7'h40}, {7'h40, 7'h40});
        end
        #2;
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step_cycle();
            checks++;
            if ({value, tick, wrap, HEX, HEX0} !== {8'(m_value), m_tick, m_wrap, m_hex, m_hex0}) begin
                errors++;
                $display("FAIL after_reset c%0d: got v=%h t=%b w=%b hex=%h/%h need v=%h t=%b w=%b hex=%h/%h",
                         c, value, tick, wrap, HEX, HEX0, 8'(m_value), m_tick, m_wrap, m_hex, m_hex0);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            en       = ($urandom_range(0, 3) != 0);
            up       = 1'($urandom_range(0, 1));
            load     = ($urandom_range(0, 15) == 0);
            load_val = 8'($urandom_range(0, 255));
            if (($urandom_range(0, 3) == 0) && (($urandom_range(0, 255) & 8'hF0) == 8'hF0)) begin
                load_val = 8'hFF;
            end
            if ($urandom_range(0, 49) == 0) begin
                reset = 1'b1;
                #1;
                model_reset();
                checks++;
                if ({value, tick, wrap, HEX, HEX0} !== {8'(m_value), m_tick, m_wrap, m_hex, m_hex0}) begin
                    errors++;
                    $display("FAIL random_rst c%0d: got v=%h t=%b w=%b hex=%h/%h need v=00 hex=%h/%h",
                             c, value, tick, wrap, HEX, HEX0, m_hex, m_hex0);
                end
            end else begin
                reset = 1'b0;
            end
            step_cycle();
            checks++;
            if ({value, tick, wrap, HEX, HEX0} !== {8'(m_value), m_tick, m_wrap, m_hex, m_hex0}) begin
                errors++;
                $display("FAIL random c%0d: got v=%h t=%b w=%b hex=%h/%h need v=%h t=%b w=%b hex=%h/%h",
                         c, value, tick, wrap, HEX, HEX0, 8'(m_value), m_tick, m_wrap, m_hex, m_hex0);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_count_up();
        test_wrap_up();
        test_wrap_down();
        test_load_mid();
        test_en_pause();
        test_lzb0();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
